// File: rtl/port_bus_if.sv
// CPU-side port bus: address, write data and strobes from the CPU;
// read data and the wait-state handshake back from the I/O hub.
interface port_bus_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] portaddr;
  logic [WORD_SIZE-1:0] portval;
  logic                 portget;
  logic                 portset;
  logic [WORD_SIZE-1:0] portout;
  logic                 portready;

  modport master (output portaddr, portval, portget, portset, input portout, portready);
  modport slave  (input portaddr, portval, portget, portset, output portout, portready);
endinterface

// File: rtl/port_bus.sv
// CPU I/O hub: scratch registers, buffered TX/RX channels, status, tick counter,
// with a wait-state handshake that stalls the CPU on a full TX or an empty RX.
module port_bus #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_REGS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DEPTH_BITS = 3
) (
  input  logic                 clk,
  input  logic                 do_reset_n,
  port_bus_if.slave            bus,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 err
);
  localparam int CNT_BITS = DEPTH_BITS + 1;
  localparam logic [WORD_SIZE-1:0] TX_ADDR     = WORD_SIZE'(NUM_REGS);
  localparam logic [WORD_SIZE-1:0] RX_ADDR     = WORD_SIZE'(NUM_REGS + 1);
  localparam logic [WORD_SIZE-1:0] STATUS_ADDR = WORD_SIZE'(NUM_REGS + 2);
  localparam logic [WORD_SIZE-1:0] TICK_ADDR   = WORD_SIZE'(NUM_REGS + 3);
  localparam logic [CNT_BITS-1:0]  FULL_COUNT  = CNT_BITS'(FIFO_DEPTH);

  logic [WORD_SIZE-1:0]  regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]  regs_d [NUM_REGS];
  logic [WORD_SIZE-1:0]  txMem_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  rxMem_q [FIFO_DEPTH];
  logic [DEPTH_BITS-1:0] txWr_q, txWr_d, txRd_q, txRd_d;
  logic [DEPTH_BITS-1:0] rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [CNT_BITS-1:0]   txCount_q, txCount_d, rxCount_q, rxCount_d;
  logic [WORD_SIZE-1:0]  tick_q, tick_d;
  logic                  err_q, err_d;

  logic isScratch, isTx, isRx, isStatus, isTick, isUnmapped;
  logic txFull, txEmpty, rxFull, rxEmpty;
  logic portReady, setOk, getOk;
  logic cpuPush, cpuPop, txPop, rxPush, errSet, errClr;
  logic [WORD_SIZE-1:0] rdata;

  // Full/empty are judged on pre-edge state, so a same-cycle pop never unblocks a push.
  always_comb begin
    isScratch  = bus.portaddr < TX_ADDR;
    isTx       = bus.portaddr == TX_ADDR;
    isRx       = bus.portaddr == RX_ADDR;
    isStatus   = bus.portaddr == STATUS_ADDR;
    isTick     = bus.portaddr == TICK_ADDR;
    isUnmapped = !(isScratch || isTx || isRx || isStatus || isTick);
    txFull     = txCount_q == FULL_COUNT;
    txEmpty    = txCount_q == '0;
    rxFull     = rxCount_q == FULL_COUNT;
    rxEmpty    = rxCount_q == '0;
    portReady  = !((bus.portset && isTx && txFull) || (bus.portget && isRx && rxEmpty));
    setOk      = bus.portset && portReady;
    getOk      = bus.portget && portReady;
    cpuPush    = setOk && isTx;
    cpuPop     = getOk && isRx;
    txPop      = !txEmpty && tx_ready;
    rxPush     = rx_valid && !rxFull;
    errSet     = isUnmapped && (setOk || getOk);
    errClr     = setOk && isStatus;
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (setOk && bus.portaddr == WORD_SIZE'(i)) regs_d[i] = bus.portval;
    end
    txWr_d    = cpuPush ? txWr_q + DEPTH_BITS'(1) : txWr_q;
    txRd_d    = txPop   ? txRd_q + DEPTH_BITS'(1) : txRd_q;
    rxWr_d    = rxPush  ? rxWr_q + DEPTH_BITS'(1) : rxWr_q;
    rxRd_d    = cpuPop  ? rxRd_q + DEPTH_BITS'(1) : rxRd_q;
    txCount_d = txCount_q + CNT_BITS'(cpuPush) - CNT_BITS'(txPop);
    rxCount_d = rxCount_q + CNT_BITS'(rxPush) - CNT_BITS'(cpuPop);
    tick_d    = (setOk && isTick) ? bus.portval : tick_q + WORD_SIZE'(1);
    err_d     = err_q;
    if (errClr) err_d = 1'b0;
    if (errSet) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge do_reset_n) begin
    if (!do_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      txWr_q    <= '0;
      txRd_q    <= '0;
      rxWr_q    <= '0;
      rxRd_q    <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      tick_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      txWr_q    <= txWr_d;
      txRd_q    <= txRd_d;
      rxWr_q    <= rxWr_d;
      rxRd_q    <= rxRd_d;
      txCount_q <= txCount_d;
      rxCount_q <= rxCount_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (cpuPush) txMem_q[txWr_q] <= bus.portval;
    if (rxPush)  rxMem_q[rxWr_q] <= rx_data;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.portaddr == WORD_SIZE'(i)) rdata = regs_q[i];
    end
    if (isTx)     rdata = WORD_SIZE'(txCount_q);
    if (isRx)     rdata = rxMem_q[rxRd_q];
    if (isStatus) rdata[4:0] = {err_q, rxFull, rxEmpty, txFull, txEmpty};
    if (isTick)   rdata = tick_q;
  end

  assign bus.portout   = rdata;
  assign bus.portready = portReady;
  assign tx_data       = txMem_q[txRd_q];
  assign tx_valid      = !txEmpty;
  assign rx_ready      = !rxFull;
  assign err           = err_q;
endmodule

// File: tb/tb_port_bus.sv
// Directed bench for port_bus: a vector table for the CPU-side map and TX path,
// plus hand-written sequences for RX stalls, RX wrap-around and reset mid-stall.
module tb_port_bus;
  localparam int WORD_SIZE  = 16;
  localparam int NUM_REGS   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DEPTH_BITS = 3;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] val;
    logic        get;
    logic        set;
    logic        txReady;
    logic        chkOut;
    logic [15:0] expOut;
    logic        expReady;
    logic        expTxValid;
    logic        chkTxData;
    logic [15:0] expTxData;
    logic        expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        do_reset_n;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[$];
  logic [15:0] model[$];
  logic [15:0] nextData;
  logic        popNow, pushNow;

  port_bus_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  port_bus #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DEPTH_BITS(DEPTH_BITS)
  ) dut (
    .clk       (clk),
    .do_reset_n(do_reset_n),
    .bus       (bus),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [15:0] addr, input logic [15:0] val, input logic get,
                        input logic set, input logic txReady, input logic chkOut,
                        input logic [15:0] expOut, input logic expReady, input logic expTxValid,
                        input logic chkTxData, input logic [15:0] expTxData, input logic expErr);
    vec_t v;
    v.addr = addr; v.val = val; v.get = get; v.set = set; v.txReady = txReady;
    v.chkOut = chkOut; v.expOut = expOut; v.expReady = expReady; v.expTxValid = expTxValid;
    v.chkTxData = chkTxData; v.expTxData = expTxData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.portaddr = v.addr;
    bus.portval  = v.val;
    bus.portget  = v.get;
    bus.portset  = v.set;
    tx_ready     = v.txReady;
    rx_valid     = 1'b0;
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    if (v.chkOut) checkOutput($sformatf("vec%0d.portout", idx), bus.portout, v.expOut);
    checkOutput($sformatf("vec%0d.portready", idx), 16'(bus.portready), 16'(v.expReady));
    checkOutput($sformatf("vec%0d.tx_valid", idx), 16'(tx_valid), 16'(v.expTxValid));
    if (v.chkTxData) checkOutput($sformatf("vec%0d.tx_data", idx), tx_data, v.expTxData);
    checkOutput($sformatf("vec%0d.err", idx), 16'(err), 16'(v.expErr));
  endtask

  task automatic buildTable();
    // Scratch registers, including same-address get+set showing the pre-write value.
    addVec(16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0002, 16'h1234, 0, 1, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0000, 16'hBEEF, 0, 1, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0002, 16'h0000, 1, 0, 0, 1, 16'h1234, 1, 0, 0, 16'h0, 0);
    addVec(16'h0000, 16'h0000, 1, 0, 0, 1, 16'hBEEF, 1, 0, 0, 16'h0, 0);
    addVec(16'h0003, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0001, 16'h5555, 1, 1, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0001, 16'h0000, 1, 0, 0, 1, 16'h5555, 1, 0, 0, 16'h0, 0);
    addVec(16'h0006, 16'h0000, 1, 0, 0, 1, 16'h0005, 1, 0, 0, 16'h0, 0);
    addVec(16'h0004, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    // Fill TX with 1..8 while the consumer is stalled.
    for (int k = 1; k <= 8; k++)
      addVec(16'h0004, 16'(k), 0, 1, 0, 1, 16'(k - 1), 1, k > 1, k > 1, 16'h0001, 0);
    addVec(16'h0006, 16'h0000, 1, 0, 0, 1, 16'h0006, 1, 1, 1, 16'h0001, 0);
    addVec(16'h0004, 16'h0000, 1, 0, 0, 1, 16'h0008, 1, 1, 1, 16'h0001, 0);
    addVec(16'h0004, 16'h0009, 0, 1, 0, 1, 16'h0008, 0, 1, 1, 16'h0001, 0);
    addVec(16'h0004, 16'h0009, 0, 1, 0, 1, 16'h0008, 0, 1, 1, 16'h0001, 0);
    addVec(16'h0004, 16'h0009, 0, 1, 1, 1, 16'h0008, 0, 1, 1, 16'h0001, 0);
    addVec(16'h0004, 16'h0009, 0, 1, 0, 1, 16'h0007, 1, 1, 1, 16'h0002, 0);
    addVec(16'h0006, 16'h0000, 1, 0, 0, 1, 16'h0006, 1, 1, 1, 16'h0002, 0);
    for (int k = 0; k < 8; k++)
      addVec(16'h0004, 16'h0000, 1, 0, 1, 1, 16'(8 - k), 1, 1, 1, 16'(2 + k), 0);
    addVec(16'h0004, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    // Tick load and wrap.
    addVec(16'h0007, 16'hFFFE, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0007, 16'h0000, 1, 0, 0, 1, 16'hFFFE, 1, 0, 0, 16'h0, 0);
    addVec(16'h0007, 16'h0000, 1, 0, 0, 1, 16'hFFFF, 1, 0, 0, 16'h0, 0);
    addVec(16'h0007, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    // Unmapped accesses set err; a STATUS write clears it.
    addVec(16'h0100, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0006, 16'h0000, 1, 0, 0, 1, 16'h0015, 1, 0, 0, 16'h0, 1);
    addVec(16'h0006, 16'h1234, 0, 1, 0, 1, 16'h0015, 1, 0, 0, 16'h0, 1);
    addVec(16'h0006, 16'h0000, 1, 0, 0, 1, 16'h0005, 1, 0, 0, 16'h0, 0);
    addVec(16'h0008, 16'h0001, 0, 1, 0, 1, 16'h0000, 1, 0, 0, 16'h0, 0);
    addVec(16'h0000, 16'h0000, 0, 0, 0, 1, 16'hBEEF, 1, 0, 0, 16'h0, 1);
    addVec(16'h0006, 16'h0000, 0, 1, 0, 1, 16'h0015, 1, 0, 0, 16'h0, 1);
    addVec(16'h0000, 16'h0000, 0, 0, 0, 1, 16'hBEEF, 1, 0, 0, 16'h0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset_n   = 1'b0;
    bus.portaddr = '0;
    bus.portval  = '0;
    bus.portget  = 1'b0;
    bus.portset  = 1'b0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.portready", 16'(bus.portready), 16'h1);
    checkOutput("reset.tx_valid", 16'(tx_valid), 16'h0);
    checkOutput("reset.rx_ready", 16'(rx_ready), 16'h1);
    checkOutput("reset.err", 16'(err), 16'h0);
    do_reset_n = 1'b1;

    buildTable();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVec(i, vecs[i]);
    end

    // CPU reads an empty RX and stalls until the producer delivers a word.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.portaddr = 16'h0005; bus.portget = 1'b1; bus.portset = 1'b0; tx_ready = 1'b0;
      rx_valid = (i == 3); rx_data = 16'h00AA;
      #1;
      checkOutput($sformatf("rxStall%0d.portready", i), 16'(bus.portready), 16'h0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    checkOutput("rxStall.portready", 16'(bus.portready), 16'h1);
    checkOutput("rxStall.portout", bus.portout, 16'h00AA);
    @(negedge clk);
    bus.portaddr = 16'h0006;
    #1;
    checkOutput("rxStall.status", bus.portout, 16'h0005);

    // Fill RX from the producer, then interleave pops and pushes across the pointer wrap.
    nextData = 16'h0100;
    bus.portget = 1'b0; bus.portaddr = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = nextData;
      #1;
      checkOutput($sformatf("rxFill%0d.rx_ready", i), 16'(rx_ready), 16'h1);
      model.push_back(nextData);
      nextData++;
    end
    @(negedge clk);
    rx_valid = 1'b0; bus.portaddr = 16'h0006; bus.portget = 1'b1;
    #1;
    checkOutput("rxFull.rx_ready", 16'(rx_ready), 16'h0);
    checkOutput("rxFull.status", bus.portout, 16'h0009);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.portaddr = 16'h0005; bus.portget = 1'b1;
      rx_valid = (i % 3 != 2); rx_data = nextData;
      #1;
      checkOutput($sformatf("rxMix%0d.portready", i), 16'(bus.portready), 16'(model.size() != 0));
      checkOutput($sformatf("rxMix%0d.rx_ready", i), 16'(rx_ready), 16'(model.size() < 8));
      if (model.size() != 0) checkOutput($sformatf("rxMix%0d.portout", i), bus.portout, model[0]);
      popNow  = model.size() != 0;
      pushNow = rx_valid && model.size() < 8;
      if (popNow) void'(model.pop_front());
      if (pushNow) begin
        model.push_back(nextData);
        nextData++;
      end
    end
    for (int i = 0; i < 16 && model.size() != 0; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
      checkOutput($sformatf("rxDrain%0d.portout", i), bus.portout, model[0]);
      void'(model.pop_front());
    end
    @(negedge clk);
    #1;
    checkOutput("rxDrain.emptyStall", 16'(bus.portready), 16'h0);

    // Reset while a TX write is stalled on a full FIFO.
    @(negedge clk);
    bus.portaddr = 16'h0200; bus.portget = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.portaddr = 16'h0004; bus.portget = 1'b0; bus.portset = 1'b1; bus.portval = 16'(k + 16'h20);
    end
    @(negedge clk);
    bus.portval = 16'h0077;
    #1;
    checkOutput("rstStall.before", 16'(bus.portready), 16'h0);
    checkOutput("rstStall.errBefore", 16'(err), 16'h1);
    @(negedge clk);
    do_reset_n = 1'b0;
    #1;
    checkOutput("rstStall.portready", 16'(bus.portready), 16'h1);
    checkOutput("rstStall.tx_valid", 16'(tx_valid), 16'h0);
    checkOutput("rstStall.rx_ready", 16'(rx_ready), 16'h1);
    checkOutput("rstStall.err", 16'(err), 16'h0);
    checkOutput("rstStall.portout", bus.portout, 16'h0000);
    @(negedge clk);
    do_reset_n = 1'b1;
    #1;
    checkOutput("rstRelease.portready", 16'(bus.portready), 16'h1);
    @(negedge clk);
    bus.portset = 1'b0; bus.portget = 1'b1;
    #1;
    checkOutput("rstRelease.txCount", bus.portout, 16'h0001);
    checkOutput("rstRelease.tx_data", tx_data, 16'h0077);
    bus.portaddr = 16'h0000;
    #1;
    checkOutput("rstRelease.scratch0", bus.portout, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
